// File: rtl/checkout_pkg.sv
// Shared types and default classification masks for the checkout lane sequencer.
package checkout_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        EVAL    = 3'd2,
        ALARM   = 3'd3,
        DONE    = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0] upc;
        logic       mark;
    } item_t;

    // Bit [upc] = 1 marks the item as discounted.
    localparam logic [7:0] DISC_MASK_DEF = 8'b1010_0011;
    // Bit [upc] = 1 marks the item as stolen when no security mark is present.
    localparam logic [7:0] RISK_MASK_DEF = 8'b0100_1001;

endpackage

// File: rtl/upc_classify.sv
// Combinational item classifier: looks up the captured UPC in the discount and
// risk masks; a risky item without its security mark is flagged stolen.
module upc_classify
    import checkout_pkg::*;
(
    input  item_t      item,
    input  logic [7:0] disc_mask,
    input  logic [7:0] risk_mask,
    output logic       disc,
    output logic       stl
);

    assign disc = disc_mask[item.upc];
    assign stl  = risk_mask[item.upc] & ~item.mark;

endmodule

// File: rtl/checkout_sequencer.sv
// Checkout lane sequencer: captures each scanned item, classifies it, keeps
// saturating per-sale counts and holds a theft alarm until a timed operator ack.
module checkout_sequencer
    import checkout_pkg::*;
#(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned ALARM_MIN = 50_000_000,
    parameter logic [7:0]  DISC_MASK = DISC_MASK_DEF,
    parameter logic [7:0]  RISK_MASK = RISK_MASK_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_req,
    input  logic             end_sale,
    input  logic             ack_alarm,
    input  logic [2:0]       upc,
    input  logic             mark,
    output logic [CNT_W-1:0] item_cnt,
    output logic [CNT_W-1:0] disc_cnt,
    output logic             last_disc,
    output logic             last_stl,
    output logic             alarm,
    output logic             busy,
    output logic             sale_done
);

    localparam int unsigned      TMR_W   = $clog2(ALARM_MIN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(ALARM_MIN);

    state_t           state;
    state_t           next_state;
    logic             scan_q;
    logic             end_q;
    logic             ack_q;
    logic             scan_edge;
    logic             end_edge;
    logic             ack_edge;
    item_t            item_q;
    logic [TMR_W-1:0] timer;
    logic             pend_end;
    logic             item_disc;
    logic             item_stl;
    logic             busy_d;
    logic             alarm_d;
    logic             sale_done_d;

    // Delayed copies of the button levels for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registers use <= so every flop samples the pre-edge values of its peers.
        if (reset) begin
            scan_q <= 1'b0;
            end_q  <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            scan_q <= scan_req;
            end_q  <= end_sale;
            ack_q  <= ack_alarm;
        end
    end

    assign scan_edge = scan_req  & ~scan_q;
    assign end_edge  = end_sale  & ~end_q;
    assign ack_edge  = ack_alarm & ~ack_q;

    upc_classify u_classify (
        .item      (item_q),
        .disc_mask (DISC_MASK),
        .risk_mask (RISK_MASK),
        .disc      (item_disc),
        .stl       (item_stl)
    );

    // State register plus the status outputs that move with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            alarm     <= 1'b0;
            sale_done <= 1'b0;
        end else begin
            state     <= next_state;
            busy      <= busy_d;
            alarm     <= alarm_d;
            sale_done <= sale_done_d;
        end
    end

    // Next-state selection; a scan edge outranks a simultaneous end-of-sale edge
    always_comb begin
        // NOTE: default first so no branch leaves next_state unassigned and infers a latch.
        next_state = state;
        unique case (state)
            IDLE: begin
                if (scan_edge)                 next_state = CAPTURE;
                else if (end_edge || pend_end) next_state = DONE;
            end
            CAPTURE: next_state = EVAL;
            EVAL:    next_state = item_stl ? ALARM : IDLE;
            ALARM: begin
                if (ack_edge && (timer == TMR_MAX)) next_state = IDLE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs decoded from the state being entered, so they register with it
    always_comb begin
        busy_d      = (next_state != IDLE);
        alarm_d     = (next_state == ALARM);
        sale_done_d = (next_state == DONE);
    end

    // Item capture, saturating counters, classification flags, alarm timer, pending end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            item_q    <= '0;
            item_cnt  <= '0;
            disc_cnt  <= '0;
            last_disc <= 1'b0;
            last_stl  <= 1'b0;
            timer     <= '0;
            pend_end  <= 1'b0;
        end else begin
            if (state == CAPTURE) begin
                item_q.upc  <= upc;
                item_q.mark <= mark;
            end

            if (state == EVAL) begin
                if (item_cnt != CNT_MAX)              item_cnt <= item_cnt + CNT_W'(1);
                if (item_disc && (disc_cnt != CNT_MAX)) disc_cnt <= disc_cnt + CNT_W'(1);
                last_disc <= item_disc;
                last_stl  <= item_stl;
            end else if (state == DONE) begin
                item_cnt  <= '0;
                disc_cnt  <= '0;
                last_disc <= 1'b0;
                last_stl  <= 1'b0;
            end

            // Timer starts from zero on alarm entry and parks at the minimum hold time
            if (state == EVAL)                             timer <= '0;
            else if ((state == ALARM) && (timer != TMR_MAX)) timer <= timer + TMR_W'(1);

            // An end request that cannot be served right away waits until IDLE
            if (state == DONE)                                     pend_end <= 1'b0;
            else if (end_edge && ((state != IDLE) || scan_edge)) pend_end <= 1'b1;
        end
    end

endmodule
